lsu_mem_adapter: RTL and testbench

- Load/store unit between the core's memory stage and the word-only data memory.
- Data memory interface: word write enable, 32-bit byte address, word read data, combinational read.
- Handles RV32I byte, halfword and word loads and stores:
  - sign- or zero-extends load data;
  - performs read-modify-write (RMW) for sub-word stores;
  - flags misaligned or illegal accesses instead of touching memory.
- Core side uses a valid/ready request and a one-cycle response pulse.

---
 rtl/lsu_mem_adapter.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core memory stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; bad accesses respond with an error.
module lsu_mem_adapter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [2:0] F3_W = 3'b010;

  state_t              state;
  logic                store_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merge_q;

  // Illegal funct3 or an address not aligned to the access size.
  function automatic logic req_bad(input logic st, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = st ? (f3 > F3_W) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal | misaligned;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/halfword lane of the captured word.
  function automatic logic [31:0] merge_word(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] word,
                                             input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (f3[0]) m[{off[1], 4'b0000} +: 16] = wd[15:0];
    else       m[{off, 3'b000} +: 8]      = wd[7:0];
    return m;
  endfunction

  assign req_ready = (state == IDLE);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    mem_we = 1'b0;
    mem_wd = '0;
    case (state)
      ACCESS: begin
        if (store_q && (funct3_q == F3_W)) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      MERGE: begin
        mem_we = 1'b1;
        mem_wd = merge_word(funct3_q, addr_q[1:0], merge_q, wdata_q);
      end
      default: ;
    endcase
  end

  // Response outputs are set on the edge entering RESP so they are high for that cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_bad(req_store, req_funct3, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!store_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_extend(funct3_q, addr_q[1:0], mem_rd);
          end else if (funct3_q == F3_W) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            merge_q <= mem_rd;
            state   <= MERGE;
          end
        end
        MERGE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a word memory model and a response scoreboard.
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_mem_adapter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_d;

  assign mem_rd = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] = pre_d;
    else if (mem_we) mem[mem_addr[11:2]] = mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int we_cyc = 0;
  logic [31:0] we_addr = '0;
  logic [31:0] we_wd = '0;
  int resp_cnt = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      we_cnt++;
      we_cyc  = cyc;
      we_addr = mem_addr;
      we_wd   = mem_wd;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata %h expected no response", resp_rdata);
      end else begin
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rd);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = addr[11:2]; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit keep, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    last_acc = cyc;
    if (push) begin
      e.rd = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
    if (!keep) #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int w0;
    int r0;
    int a0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_d = '0;
    preload(32'h100, 32'h8899AABB);
    preload(32'h300, 32'hDEADBEEF);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1'b0, 1'b1); wait_done();
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 2, 1'b0, 1'b1); wait_done();
    issue(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 2, 1'b0, 1'b1); wait_done();
    issue(1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1'b0, 1'b1); wait_done();
    issue(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1'b0, 1'b1); wait_done();

    w0 = we_cnt;
    issue(1'b1, 3'b010, 32'h200, 32'h12345678, 32'h0, 1'b0, 2, 1'b0, 1'b1); wait_done();
    check("sw_we_count", 32'(we_cnt - w0), 32'd1);
    check("sw_we_cycle", 32'(we_cyc - last_acc), 32'd1);
    check("sw_we_addr", we_addr, 32'h200);
    check("sw_we_data", we_wd, 32'h12345678);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0, 2, 1'b0, 1'b1); wait_done();

    w0 = we_cnt;
    issue(1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1'b0, 3, 1'b0, 1'b1); wait_done();
    check("sb_we_count", 32'(we_cnt - w0), 32'd1);
    check("sb_we_cycle", 32'(we_cyc - last_acc), 32'd2);
    check("sb_we_data", we_wd, 32'hDEADA5EF);
    check("sb_mem_word", mem[32'h300 >> 2], 32'hDEADA5EF);
    issue(1'b1, 3'b001, 32'h302, 32'h00001234, 32'h0, 1'b0, 3, 1'b0, 1'b1); wait_done();
    check("sh_mem_word", mem[32'h300 >> 2], 32'h1234A5EF);
    issue(1'b1, 3'b000, 32'h303, 32'h11223344, 32'h0, 1'b0, 3, 1'b0, 1'b1); wait_done();
    check("sb3_mem_word", mem[32'h300 >> 2], 32'h4434A5EF);

    w0 = we_cnt;
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1); wait_done();
    issue(1'b1, 3'b010, 32'h202, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, 1'b1); wait_done();
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1); wait_done();
    issue(1'b1, 3'b100, 32'h300, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0, 1'b1); wait_done();
    check("err_no_write", 32'(we_cnt - w0), 32'd0);
    check("err_mem_200", mem[32'h200 >> 2], 32'h12345678);

    r0 = resp_cnt;
    issue(1'b1, 3'b000, 32'h300, 32'h000000FF, 32'h0, 1'b0, 3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("merge_we_high", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("rst_mem_kept", mem[32'h300 >> 2], 32'h4434A5EF);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h4434A5EF, 1'b0, 2, 1'b0, 1'b1); wait_done();

    issue(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, 1'b1);
    a0 = last_acc;
    issue(1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, 1'b1);
    check("b2b_accept_gap", 32'(last_acc - a0), 32'd3);
    wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
